// File: rtl/pcm_pkg.sv
// Shared PCM codec definitions: mode encodings, sample/code widths and the
// channel-tag width helper.
package pcm_pkg;

    localparam int unsigned LIN_W  = 13;
    localparam int unsigned CODE_W = 8;

    typedef enum logic {
        MODE_EXPAND   = 1'b0,
        MODE_COMPRESS = 1'b1
    } pcm_mode_e;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pcm_codec_if.sv
// Sample-stream interface of the PCM codec: input handshake, output handshake
// and the processed-sample counter.
interface pcm_codec_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 16
);
    import pcm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [CH_W-1:0]   in_chan;
    logic [LIN_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_mode;
    logic [CH_W-1:0]   out_chan;
    logic [LIN_W-1:0]  out_data;
    logic [CNT_W-1:0]  sample_cnt;

    modport master (
        output in_valid, in_mode, in_chan, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_chan, out_data, sample_cnt
    );

    modport slave (
        input  in_valid, in_mode, in_chan, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_chan, out_data, sample_cnt
    );

endinterface

// File: rtl/pcm_seg_conv.sv
// Combinational A-law segment conversion, both directions, mode-selected.
// Macro PCM_CODEC_XOR_EN enables the even-bit (8'h55) code inversion.
module pcm_seg_conv
    import pcm_pkg::*;
(
    input  pcm_mode_e          i_mode,
    input  logic [LIN_W-1:0]   i_data,
    output logic [LIN_W-1:0]   o_data
);

    logic [CODE_W-1:0] w_code;
    logic [11:0]       w_exp_mag;
    logic [LIN_W-1:0]  w_exp;
    logic [11:0]       w_cmp_mag;
    logic [2:0]        w_seg;
    logic [3:0]        w_man;
    logic [CODE_W-1:0] w_cmp_raw;
    logic [CODE_W-1:0] w_cmp;

`ifdef PCM_CODEC_XOR_EN
    assign w_code = i_data[7:0] ^ 8'h55;
    assign w_cmp  = w_cmp_raw ^ 8'h55;
`else
    assign w_code = i_data[7:0];
    assign w_cmp  = w_cmp_raw;
`endif

    // Segment k>=1 places {1, m, 1} with its leading one at bit k+4.
    always_comb begin
        w_exp_mag = '0;
        if (w_code[6:4] == 3'd0) begin
            w_exp_mag = {7'b0, w_code[3:0], 1'b1};
        end else begin
            w_exp_mag = {6'b0, 1'b1, w_code[3:0], 1'b1} << (w_code[6:4] - 3'd1);
        end
    end

    assign w_exp     = {w_code[7], w_exp_mag};
    assign w_cmp_mag = i_data[11:0];

    always_comb begin
        w_seg = '0;
        w_man = w_cmp_mag[4:1];
        for (int unsigned i = 5; i < 12; i++) begin
            if (w_cmp_mag[i]) begin
                w_seg = 3'(i - 4);
                w_man = 4'(w_cmp_mag >> (i - 4));
            end
        end
    end

    assign w_cmp_raw = {i_data[12], w_seg, w_man};
    assign o_data    = (i_mode == MODE_COMPRESS) ? {5'b0, w_cmp} : w_exp;

endmodule

// File: rtl/pcm_codec.sv
// Two-stage valid/ready A-law PCM expander/compressor with channel tags and
// an output-transfer counter. Optional macro: PCM_CODEC_XOR_EN.
module pcm_codec
    import pcm_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 16
)(
    input  logic             clk,
    input  logic             rst,
    pcm_codec_if.slave       bus
);

    localparam int unsigned CH_W = ch_width(CHANNELS);

    logic              r_s1_valid;
    pcm_mode_e         r_s1_mode;
    logic [CH_W-1:0]   r_s1_chan;
    logic [LIN_W-1:0]  r_s1_data;

    logic              r_s2_valid;
    logic              r_s2_mode;
    logic [CH_W-1:0]   r_s2_chan;
    logic [LIN_W-1:0]  r_s2_data;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_in_ready;
    logic              w_out_xfer;
    logic [LIN_W-1:0]  w_conv;

    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_adv;
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign w_out_xfer = r_s2_valid && bus.out_ready;

    pcm_seg_conv u_conv (
        .i_mode (r_s1_mode),
        .i_data (r_s1_data),
        .o_data (w_conv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= MODE_EXPAND;
            r_s1_chan  <= '0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_mode  <= 1'b0;
            r_s2_chan  <= '0;
            r_s2_data  <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_mode <= pcm_mode_e'(bus.in_mode);
                    r_s1_chan <= bus.in_chan;
                    r_s1_data <= bus.in_data;
                end
            end
            // Result registers only move when they are free or being drained.
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_mode <= r_s1_mode;
                    r_s2_chan <= r_s1_chan;
                    r_s2_data <= w_conv;
                end
            end
            if (w_out_xfer) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // out_valid is masked while rst is high so a flushed sample never transfers.
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_s2_valid && !rst;
    assign bus.out_mode   = r_s2_mode;
    assign bus.out_chan   = r_s2_chan;
    assign bus.out_data   = r_s2_data;
    assign bus.sample_cnt = r_cnt;

endmodule

// File: tb/tb_pcm_codec.sv
// Directed self-checking bench for pcm_codec; honours PCM_CODEC_XOR_EN.
module tb_pcm_codec;
    import pcm_pkg::*;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned CH_W     = 2;
`ifdef PCM_CODEC_XOR_EN
    localparam logic [7:0] XK = 8'h55;
`else
    localparam logic [7:0] XK = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pcm_codec_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    pcm_codec #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction with out_ready high; returns the result.
    task automatic xfer(input logic mode, input logic [12:0] data, output logic [12:0] res);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = mode;
        bus.in_chan   = 2'd2;
        bus.in_data   = data;
        #1;
        check("xfer in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("xfer lat1 valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("xfer lat2 valid", 32'(bus.out_valid), 32'd1);
        check("xfer mode", 32'(bus.out_mode), 32'(mode));
        check("xfer chan", 32'(bus.out_chan), 32'd2);
        res = bus.out_data;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [12:0] r;
        logic [12:0] e;
        logic [7:0]  bp_code [4];
        logic [12:0] bp_exp  [4];
        int          acc;
        int          got;
        logic        a;

        bp_code = '{8'h10, 8'h20, 8'h30, 8'h40};
        bp_exp  = '{13'h0021, 13'h0042, 13'h0084, 13'h0108};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_chan = '0;
        bus.in_data = '0; bus.out_ready = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'd0);
        check("rst out_chan", 32'(bus.out_chan), 32'd0);
        check("rst out_mode", 32'(bus.out_mode), 32'd0);
        check("rst sample_cnt", 32'(bus.sample_cnt), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);

        // Directed expand/compress vectors
        xfer(1'b0, {5'b0, 8'h00 ^ XK}, r); check("exp 00", 32'(r), 32'h0001);
        xfer(1'b0, {5'b0, 8'h9F ^ XK}, r); check("exp 9F", 32'(r), 32'h103F);
        xfer(1'b0, {5'b0, 8'h7A ^ XK}, r); check("exp 7A", 32'(r), 32'h0D40);
        xfer(1'b0, {5'h1F, 8'h7A ^ XK}, r); check("exp hi ignored", 32'(r), 32'h0D40);
        xfer(1'b1, 13'h0D40, r); check("cmp 0D40", 32'(r), 32'({5'b0, 8'h7A ^ XK}));
        xfer(1'b1, 13'h0000, r); check("cmp 0000", 32'(r), 32'({5'b0, 8'h00 ^ XK}));
        xfer(1'b1, 13'h1FFF, r); check("cmp 1FFF", 32'(r), 32'({5'b0, 8'hFF ^ XK}));
`ifdef PCM_CODEC_XOR_EN
        xfer(1'b1, 13'h0000, r); check("xor cmp 0000", 32'(r), 32'h0055);
        xfer(1'b0, 13'h0055, r); check("xor exp 55", 32'(r), 32'h0001);
`endif

        for (int c = 0; c < 256; c++) begin
            xfer(1'b0, {5'b0, 8'(c) ^ XK}, e);
            xfer(1'b1, e, r);
            check("sweep roundtrip", 32'(r), 32'({5'b0, 8'(c) ^ XK}));
        end

        // Backpressure: 4 samples offered while out_ready is low
        bus.out_ready = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            bus.in_valid = (acc < 4);
            bus.in_mode  = 1'b0;
            bus.in_chan  = 2'(acc);
            bus.in_data  = {5'b0, bp_code[2'(acc)] ^ XK};
            #1;
            check("bp in_ready", 32'(bus.in_ready), (cyc < 2) ? 32'd1 : 32'd0);
            if (cyc >= 2) check("bp held data", 32'(bus.out_data), 32'h0021);
            a = bus.in_valid && bus.in_ready;
            tick();
            if (a) acc++;
        end
        check("bp accepted", 32'(acc), 32'd2);
        check("bp held valid", 32'(bus.out_valid), 32'd1);
        check("bp held chan", 32'(bus.out_chan), 32'd0);

        bus.out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
            if (bus.out_valid) begin
                check("bp order chan", 32'(bus.out_chan), 32'(got));
                check("bp order data", 32'(bus.out_data), 32'(bp_exp[2'(got)]));
                got++;
            end
            bus.in_valid = (acc < 4);
            bus.in_chan  = 2'(acc);
            bus.in_data  = {5'b0, bp_code[2'(acc)] ^ XK};
            #1;
            a = bus.in_valid && bus.in_ready;
            tick();
            if (a) acc++;
        end
        bus.in_valid = 1'b0;
        check("bp out count", 32'(got), 32'd4);

        // Streaming: 10 back-to-back samples after a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        check("stream pre cnt", 32'(bus.sample_cnt), 32'd0);
        acc = 0; got = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (bus.out_valid) begin
                check("stream data", 32'(bus.out_data), 32'(2 * got + 1));
                check("stream chan", 32'(bus.out_chan), 32'(got % 4));
                check("stream spacing", 32'(cyc), 32'(got + 2));
                got++;
            end
            bus.in_valid = (acc < 10);
            bus.in_mode  = 1'b0;
            bus.in_chan  = 2'(acc);
            bus.in_data  = {5'b0, 8'(acc) ^ XK};
            #1;
            if (acc < 10) check("stream in_ready", 32'(bus.in_ready), 32'd1);
            a = bus.in_valid && bus.in_ready;
            tick();
            if (a) acc++;
        end
        bus.in_valid = 1'b0;
        check("stream out count", 32'(got), 32'd10);
        check("stream sample_cnt", 32'(bus.sample_cnt), 32'd10);

        // Reset with two samples in flight
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_chan  = 2'(k + 1);
            bus.in_data  = {5'b0, 8'(5 + k) ^ XK};
            tick();
        end
        bus.in_valid = 1'b0;
        check("flush pre valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("flush rst valid", 32'(bus.out_valid), 32'd0);
        tick();
        rst = 1'b0;
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        check("flush sample_cnt", 32'(bus.sample_cnt), 32'd0);
        check("flush out_data", 32'(bus.out_data), 32'd0);
        check("flush in_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("flush no emit", 32'(bus.out_valid), 32'd0);
        end
        check("flush final cnt", 32'(bus.sample_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
